// File: rtl/text_buffer_arbiter_pkg.sv
// Shared definitions for the text buffer arbiter: controller state encoding
// and the default blank character code.
package text_buffer_arbiter_pkg;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } arb_state_e;

    localparam logic [8:0] BLANK_DEFAULT = 9'h000;

endpackage

// File: rtl/sync_fifo_wr.sv
// Small synchronous FIFO buffering editor writes ({addr,data} payload).
// Pushes while full and pops while empty are ignored; flush empties it.
module sync_fifo_wr #(
    parameter int unsigned WIDTH = 19,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     i_clk,
    input  logic                     i_Reset_n,
    input  logic                     i_Flush,
    input  logic                     i_Push,
    input  logic [WIDTH-1:0]         i_PushData,
    input  logic                     i_Pop,
    output logic [WIDTH-1:0]         o_PopData,
    output logic                     o_Full,
    output logic                     o_Empty,
    output logic [$clog2(DEPTH):0]   o_Count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok;
    logic             pop_ok;

    assign o_Full    = (count_q == FULL_CNT);
    assign o_Empty   = (count_q == '0);
    assign o_Count   = count_q;
    assign o_PopData = mem_q[rd_ptr_q];

    assign push_ok = i_Push & ~o_Full;
    assign pop_ok  = i_Pop & ~o_Empty;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = i_PushData;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (push_ok && !pop_ok) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop_ok && !push_ok) begin
            count_d = count_q - CNT_W'(1);
        end
        if (i_Flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge i_clk) begin
        mem_q <= mem_d;
        if (!i_Reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/text_buffer_arbiter.sv
// Character RAM owner: arbitrates video reads, buffered editor writes and the
// clear-screen sweep onto a single-port RAM with combinational RAM outputs.
module text_buffer_arbiter
    import text_buffer_arbiter_pkg::*;
#(
    parameter int unsigned          ADDR_W     = 10,
    parameter int unsigned          DATA_W     = 9,
    parameter int unsigned          FIFO_DEPTH = 4,
    parameter logic [DATA_W-1:0]    BLANK      = DATA_W'(BLANK_DEFAULT)
) (
    input  logic              i_clk,
    input  logic              i_Reset_n,
    input  logic              i_VidReq,
    input  logic [ADDR_W-1:0] i_VidAddr,
    output logic [DATA_W-1:0] o_VidData,
    output logic              o_VidValid,
    input  logic              i_WrReq,
    input  logic [ADDR_W-1:0] i_WrAddr,
    input  logic [DATA_W-1:0] i_WrData,
    output logic              o_WrAck,
    output logic              o_WrFull,
    input  logic              i_Clear,
    output logic              o_Busy,
    output logic              o_Overflow,
    output logic [ADDR_W-1:0] o_RamAddr,
    output logic              o_RamWe,
    output logic [DATA_W-1:0] o_RamData,
    input  logic [DATA_W-1:0] i_RamData
);

    localparam int unsigned PAY_W = ADDR_W + DATA_W;
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    arb_state_e        state_q, state_d;
    logic [ADDR_W-1:0] sweep_q, sweep_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic              overflow_q, overflow_d;
    logic              vid_valid_q, vid_valid_d;

    logic              fifo_pop;
    logic [PAY_W-1:0]  fifo_head;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CNT_W-1:0]  fifo_count;

    sync_fifo_wr #(
        .WIDTH (PAY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_wr_fifo (
        .i_clk      (i_clk),
        .i_Reset_n  (i_Reset_n),
        .i_Flush    (i_Clear),
        .i_Push     (o_WrAck),
        .i_PushData ({i_WrAddr, i_WrData}),
        .i_Pop      (fifo_pop),
        .o_PopData  (fifo_head),
        .o_Full     (fifo_full),
        .o_Empty    (fifo_empty),
        .o_Count    (fifo_count)
    );

    // Full flag and count must agree; count is what the accept rule is defined on.
    always_comb begin
        assert (fifo_full == (fifo_count == FULL_CNT));
    end

    // Reset is folded into the combinational outputs so they read as reset values
    // while i_Reset_n is held low, not just after the first reset edge.
    assign o_WrFull   = fifo_full | (state_q == ST_CLEAR) | ~i_Reset_n;
    assign o_WrAck    = i_WrReq & ~o_WrFull;
    assign o_Busy     = (state_q == ST_CLEAR) | ~i_Reset_n;
    assign o_Overflow = overflow_q;
    assign o_VidValid = vid_valid_q;
    assign o_VidData  = i_RamData;

    always_comb begin
        state_d     = state_q;
        sweep_d     = sweep_q;
        overflow_d  = overflow_q | (i_WrReq & o_WrFull);
        vid_valid_d = i_VidReq;
        ram_addr_d  = ram_addr_q;
        o_RamWe     = 1'b0;
        o_RamData   = '0;
        fifo_pop    = 1'b0;

        if (i_VidReq) begin
            ram_addr_d = i_VidAddr;
        end else if (state_q == ST_CLEAR) begin
            ram_addr_d = sweep_q;
            o_RamWe    = 1'b1;
            o_RamData  = BLANK;
            sweep_d    = sweep_q + ADDR_W'(1);
            if (&sweep_q) begin
                state_d = ST_RUN;
            end
        end else if (!fifo_empty) begin
            fifo_pop   = 1'b1;
            ram_addr_d = fifo_head[PAY_W-1:DATA_W];
            o_RamWe    = 1'b1;
            o_RamData  = fifo_head[DATA_W-1:0];
        end

        if (i_Clear) begin
            state_d = ST_CLEAR;
            sweep_d = '0;
        end

        if (!i_Reset_n) begin
            ram_addr_d = '0;
            o_RamWe    = 1'b0;
            o_RamData  = '0;
            fifo_pop   = 1'b0;
        end
    end

    assign o_RamAddr = ram_addr_d;

    always_ff @(posedge i_clk) begin
        if (!i_Reset_n) begin
            state_q     <= ST_CLEAR;
            sweep_q     <= '0;
            ram_addr_q  <= '0;
            overflow_q  <= 1'b0;
            vid_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sweep_q     <= sweep_d;
            ram_addr_q  <= ram_addr_d;
            overflow_q  <= overflow_d;
            vid_valid_q <= vid_valid_d;
        end
    end

endmodule

// File: tb/tb_text_buffer_arbiter.sv
// Directed bench for text_buffer_arbiter with a behavioural 1-cycle-latency RAM.
module tb_text_buffer_arbiter;

    localparam int AW = 10;
    localparam int DW = 9;

    logic          i_clk = 1'b0;
    logic          i_Reset_n;
    logic          i_VidReq;
    logic [AW-1:0] i_VidAddr;
    logic [DW-1:0] o_VidData;
    logic          o_VidValid;
    logic          i_WrReq;
    logic [AW-1:0] i_WrAddr;
    logic [DW-1:0] i_WrData;
    logic          o_WrAck;
    logic          o_WrFull;
    logic          i_Clear;
    logic          o_Busy;
    logic          o_Overflow;
    logic [AW-1:0] o_RamAddr;
    logic          o_RamWe;
    logic [DW-1:0] o_RamData;
    logic [DW-1:0] i_RamData;

    logic [DW-1:0] ram [1024];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 i_clk = ~i_clk;

    text_buffer_arbiter #(
        .ADDR_W     (AW),
        .DATA_W     (DW),
        .FIFO_DEPTH (4),
        .BLANK      (9'h000)
    ) dut (
        .i_clk      (i_clk),
        .i_Reset_n  (i_Reset_n),
        .i_VidReq   (i_VidReq),
        .i_VidAddr  (i_VidAddr),
        .o_VidData  (o_VidData),
        .o_VidValid (o_VidValid),
        .i_WrReq    (i_WrReq),
        .i_WrAddr   (i_WrAddr),
        .i_WrData   (i_WrData),
        .o_WrAck    (o_WrAck),
        .o_WrFull   (o_WrFull),
        .i_Clear    (i_Clear),
        .o_Busy     (o_Busy),
        .o_Overflow (o_Overflow),
        .o_RamAddr  (o_RamAddr),
        .o_RamWe    (o_RamWe),
        .o_RamData  (o_RamData),
        .i_RamData  (i_RamData)
    );

    always @(posedge i_clk) begin
        if (o_RamWe) ram[o_RamAddr] <= o_RamData;
        i_RamData <= ram[o_RamAddr];
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    logic [AW-1:0] bw_addr [4];
    logic [DW-1:0] bw_data [4];
    logic          prev_vid;
    int            wait_cnt;

    initial begin
        bw_addr[0] = 10'h040; bw_data[0] = 9'h0A5;
        bw_addr[1] = 10'h041; bw_data[1] = 9'h001;
        bw_addr[2] = 10'h042; bw_data[2] = 9'h002;
        bw_addr[3] = 10'h041; bw_data[3] = 9'h0FE;
        for (int a = 0; a < 1024; a++) ram[a] = 9'h1FF;

        i_Reset_n = 1'b0; i_VidReq = 1'b0; i_VidAddr = '0;
        i_WrReq = 1'b1; i_WrAddr = '0; i_WrData = '0; i_Clear = 1'b0;
        for (int k = 0; k < 3; k++) step();
        #3;
        check_eq("rst_we", o_RamWe, 0);
        check_eq("rst_addr", o_RamAddr, 0);
        check_eq("rst_data", o_RamData, 0);
        check_eq("rst_busy", o_Busy, 1);
        check_eq("rst_full", o_WrFull, 1);
        check_eq("rst_ack", o_WrAck, 0);
        check_eq("rst_ovf", o_Overflow, 0);
        check_eq("rst_vvalid", o_VidValid, 0);

        // Power-on sweep: one blank write per cycle
        step(); i_Reset_n = 1'b1; i_WrReq = 1'b0; #3;
        for (int k = 0; k < 1024; k++) begin
            if (k > 0) begin step(); #3; end
            check_eq("sweep_we", o_RamWe, 1);
            check_eq("sweep_addr", o_RamAddr, k);
            check_eq("sweep_busy", o_Busy, 1);
            check_eq("sweep_full", o_WrFull, 1);
        end
        step(); #3;
        check_eq("run_busy", o_Busy, 0);
        check_eq("run_full", o_WrFull, 0);
        check_eq("run_we", o_RamWe, 0);
        check_eq("run_addr_hold", o_RamAddr, 10'h3FF);
        check_eq("ram0_blank", ram[0], 0);
        check_eq("ram3ff_blank", ram[1023], 0);

        // Single write
        step(); i_WrReq = 1'b1; i_WrAddr = 10'h005; i_WrData = 9'h11C; #3;
        check_eq("w1_ack", o_WrAck, 1);
        check_eq("w1_we_same", o_RamWe, 0);
        step(); i_WrReq = 1'b0; #3;
        check_eq("w1_we", o_RamWe, 1);
        check_eq("w1_addr", o_RamAddr, 10'h005);
        check_eq("w1_data", o_RamData, 9'h11C);
        step(); #3;
        check_eq("w1_idle_we", o_RamWe, 0);
        check_eq("w1_idle_addr", o_RamAddr, 10'h005);

        // Video held high for 10 cycles while the FIFO fills
        step(); i_VidReq = 1'b1; i_VidAddr = 10'h100;
        for (int j = 0; j < 4; j++) begin
            if (j > 0) step();
            i_WrReq = 1'b1; i_WrAddr = bw_addr[j]; i_WrData = bw_data[j]; #3;
            check_eq("fill_ack", o_WrAck, 1);
            check_eq("fill_we", o_RamWe, 0);
            check_eq("fill_addr", o_RamAddr, 10'h100);
            check_eq("fill_vvalid", o_VidValid, (j > 0) ? 1 : 0);
        end
        step(); i_WrAddr = 10'h070; i_WrData = 9'h077; #3;
        check_eq("full_flag", o_WrFull, 1);
        check_eq("full_ack", o_WrAck, 0);
        check_eq("full_vdata", o_VidData, 0);
        step(); i_WrReq = 1'b0; #3;
        check_eq("ovf_set", o_Overflow, 1);
        for (int j = 0; j < 4; j++) begin
            step(); #3;
            check_eq("hold_we", o_RamWe, 0);
        end
        step(); i_VidReq = 1'b0; #3;
        for (int j = 0; j < 4; j++) begin
            if (j > 0) begin step(); #3; end
            check_eq("drain_we", o_RamWe, 1);
            check_eq("drain_addr", o_RamAddr, bw_addr[j]);
            check_eq("drain_data", o_RamData, bw_data[j]);
            if (j == 0) check_eq("drain_full0", o_WrFull, 1);
            if (j == 1) check_eq("drain_full1", o_WrFull, 0);
        end
        step(); #3;
        check_eq("drain_idle", o_RamWe, 0);
        check_eq("ovf_sticky", o_Overflow, 1);

        // Video read of a written cell; write queued in the same cycle waits
        step(); i_VidReq = 1'b1; i_VidAddr = 10'h040;
        i_WrReq = 1'b1; i_WrAddr = 10'h050; i_WrData = 9'h033; #3;
        check_eq("vr_we", o_RamWe, 0);
        check_eq("vr_addr", o_RamAddr, 10'h040);
        check_eq("vr_ack", o_WrAck, 1);
        step(); i_VidReq = 1'b0; i_WrReq = 1'b0; #3;
        check_eq("vr_valid", o_VidValid, 1);
        check_eq("vr_data", o_VidData, 9'h0A5);
        check_eq("vr_wr_we", o_RamWe, 1);
        check_eq("vr_wr_addr", o_RamAddr, 10'h050);
        check_eq("vr_wr_data", o_RamData, 9'h033);
        step(); #3;
        check_eq("vr_valid_drop", o_VidValid, 0);
        check_eq("same_addr_last", ram[10'h041], 9'h0FE);
        check_eq("ram_042", ram[10'h042], 9'h002);
        check_eq("ram_050", ram[10'h050], 9'h033);

        // Clear with three writes queued behind video traffic
        step(); i_VidReq = 1'b1; i_VidAddr = 10'h3FF;
        for (int j = 0; j < 3; j++) begin
            if (j > 0) step();
            i_WrReq = 1'b1; i_WrAddr = AW'(10'h060 + j); i_WrData = DW'(9'h111 + j); #3;
            check_eq("cq_ack", o_WrAck, 1);
        end
        step(); i_WrReq = 1'b0; i_Clear = 1'b1; #3;
        check_eq("cq_we", o_RamWe, 0);
        step(); i_Clear = 1'b0;
        prev_vid = 1'b1;
        for (int i = 0; i < 2048; i++) begin
            if (i > 0) step();
            i_VidReq = (i % 2) == 1; #3;
            check_eq("alt_vvalid", o_VidValid, prev_vid);
            check_eq("alt_busy", o_Busy, (i < 2047) ? 1 : 0);
            if (i_VidReq) begin
                check_eq("alt_vid_we", o_RamWe, 0);
                check_eq("alt_vid_addr", o_RamAddr, 10'h3FF);
            end else begin
                check_eq("alt_sw_we", o_RamWe, 1);
                check_eq("alt_sw_addr", o_RamAddr, i / 2);
                check_eq("alt_sw_data", o_RamData, 0);
            end
            prev_vid = i_VidReq;
        end
        step(); i_VidReq = 1'b0; #3;
        check_eq("flush_no_we", o_RamWe, 0);
        step(); #3;
        check_eq("flush_no_we2", o_RamWe, 0);
        check_eq("flush_ram060", ram[10'h060], 0);
        check_eq("clear_ram050", ram[10'h050], 0);

        // Reset mid-operation with a queued write
        step(); i_VidReq = 1'b1; i_WrReq = 1'b1; i_WrAddr = 10'h080; i_WrData = 9'h088; #3;
        check_eq("mr_ack", o_WrAck, 1);
        step(); i_WrReq = 1'b0; i_Reset_n = 1'b0; #3;
        check_eq("mr_we", o_RamWe, 0);
        check_eq("mr_busy", o_Busy, 1);
        check_eq("mr_full", o_WrFull, 1);
        step(); i_Reset_n = 1'b1; i_VidReq = 1'b0; #3;
        check_eq("mr_ovf_clr", o_Overflow, 0);
        check_eq("mr_vvalid", o_VidValid, 0);
        check_eq("mr_sweep_we", o_RamWe, 1);
        check_eq("mr_sweep_addr", o_RamAddr, 0);
        check_eq("mr_busy2", o_Busy, 1);
        step(); i_WrReq = 1'b1; i_WrAddr = 10'h090; i_WrData = 9'h001; #3;
        check_eq("clr_req_ack", o_WrAck, 0);
        step(); i_WrReq = 1'b0; #3;
        check_eq("clr_req_ovf", o_Overflow, 1);
        wait_cnt = 0;
        while (o_Busy && wait_cnt < 2000) begin
            step(); #3;
            wait_cnt++;
        end
        check_eq("mr_sweep_done", o_Busy, 0);
        check_eq("mr_fifo_empty", o_RamWe, 0);
        check_eq("mr_ram080", ram[10'h080], 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/text_buffer_arbiter.md
Name: text_buffer_arbiter

Overview:
Owns the single-port 9-bit character RAM that backs the text console. It arbitrates RAM cycles between two requesters:
- the VGA character fetch, which has fixed priority and fixed latency;
- keyboard/editor writes, buffered in a small write FIFO with a req/ack handshake.

It also runs a clear-screen sequencer that fills the buffer with blank codes after reset or on command. It sits between the keyboard editor logic, the VGA text renderer and the RAM macro.

Parameters:
- ADDR_W, 10, RAM address width; the buffer holds 2^ADDR_W cells.
- DATA_W, 9, cell width: bit 8 = case/attribute flag, bits 7:0 = key code.
- FIFO_DEPTH, 4, write FIFO entries; must be a power of 2, minimum 2.
- BLANK, 9'h000, code written by the clear sequencer.

Ports:
- i_clk  in  1  system clock.
- i_Reset_n  in  1  synchronous, active-low reset.
- i_VidReq  in  1  video read request for this cycle.
- i_VidAddr  in  ADDR_W  video read address.
- o_VidData  out  DATA_W  read data; equals i_RamData.
- o_VidValid  out  1  o_VidData is valid this cycle.
- i_WrReq  in  1  editor write request.
- i_WrAddr  in  ADDR_W  editor write address.
- i_WrData  in  DATA_W  editor write data.
- o_WrAck  out  1  write accepted into FIFO this cycle.
- o_WrFull  out  1  FIFO full, or controller not accepting writes.
- i_Clear  in  1  one-cycle pulse: start a clear-screen sweep.
- o_Busy  out  1  clear sweep in progress.
- o_Overflow  out  1  sticky; i_WrReq seen while o_WrFull was high.
- o_RamAddr  out  ADDR_W  RAM address.
- o_RamWe  out  1  RAM write enable.
- o_RamData  out  DATA_W  RAM write data.
- i_RamData  in  DATA_W  RAM read data, 1-cycle synchronous latency.

Behaviour:
- State machine: two states, CLEAR and RUN. Reset enters CLEAR with the sweep counter at 0.
- Reset values: o_VidValid=0, o_RamWe=0, o_RamAddr=0, o_RamData=0, o_Busy=1, o_WrFull=1, o_WrAck=0, o_Overflow=0. FIFO is empty.
- Grant priority per cycle, checked in this order:
  1. i_VidReq=1: read. o_RamAddr=i_VidAddr, o_RamWe=0.
  2. CLEAR: sweep write. o_RamAddr=counter, o_RamData=BLANK, o_RamWe=1.
  3. RUN and FIFO not empty: pop the head and write it. o_RamWe=1.
  4. Otherwise: idle. o_RamWe=0; o_RamAddr holds its last value.
- RAM outputs (o_RamAddr, o_RamWe, o_RamData) are combinational from the grant decision. No registered stage.
- Video latency: o_VidValid is the registered i_VidReq, high exactly 1 cycle after the request. o_VidData = i_RamData, no extra register. Video is never stalled.
- CLEAR sweep:
  - The counter increments only on cycles where the sweep write is granted.
  - After the write to address 2^ADDR_W-1, move to RUN; o_Busy drops on the next cycle.
  - A sweep takes 2^ADDR_W non-video cycles.
- i_Clear while in RUN: the next state is CLEAR with counter 0, and the FIFO is flushed. Pending writes are discarded by design, because they target a screen that is being erased.
- i_Clear while in CLEAR: the counter restarts at 0.
- Write accept:
  - o_WrAck = i_WrReq & ~o_WrFull, combinational, in the same cycle.
  - o_WrFull = (count==FIFO_DEPTH) | (state==CLEAR). It is evaluated from the registered count, before any same-cycle pop.
  - When full, a simultaneous push and pop refuses the push.
  - When not full, a simultaneous push and pop leaves count unchanged.
- Ordering: FIFO writes reach RAM in acceptance order. Two entries to the same address: the last one wins.
- o_Overflow is set by i_WrReq & o_WrFull, including requests made during CLEAR. It clears only on reset.
- Reset mid-operation: synchronous reset overrides everything in that cycle. The sweep restarts from 0 and the FIFO is emptied.
- Counters: all are ADDR_W or log2(FIFO_DEPTH)+1 bits wide and wrap naturally. FIFO pointers are log2(FIFO_DEPTH) bits wide.

Decomposition:
- Shared package: the state encoding (CLEAR/RUN) and the BLANK default code.
- Sub-module: one sub-module, sync_fifo_wr. It is a parameterised FIFO with push/pop/full/empty/count; the payload is {addr,data}.
- The arbiter, sweep counter and overflow flag stay in the top module.

Test Plan:
- Reset release, i_VidReq=0 throughout → RAM addresses 0..1023 written with BLANK, one per cycle. o_Busy falls on cycle 1025 after reset release. o_WrFull falls on the same cycle.
- In RUN, write {0x005, 0x11C} with i_VidReq=0 → o_WrAck the same cycle; next cycle o_RamWe=1, o_RamAddr=0x005, o_RamData=0x11C.
- i_VidReq held high for 10 cycles while 4 writes are pushed → FIFO reaches full, and a 5th request gets o_WrAck=0 and sets o_Overflow=1. After i_VidReq drops, the 4 writes drain in order over 4 cycles.
- Video read of addr 0x040 after it was written with 0x0A5 → o_VidValid=1 exactly 1 cycle later, o_VidData=0x0A5. No write is granted in the request cycle.
- i_Clear pulse with 3 entries queued → FIFO flushed and none of the 3 writes reach RAM. o_Busy=1 and the sweep restarts at address 0.
- Alternating i_VidReq 1/0 during CLEAR → sweep advances only on the 0 cycles, so the sweep takes 2048 cycles. Every video request still gets o_VidValid 1 cycle later.
